// File: rtl/max_pool_window_feeder_pkg.sv
// Shared CNN parameters and state encoding for the max-pool window feeder.
package max_pool_window_feeder_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned CLK_NUM_WIDTH = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StDrain   = 3'd2,
        StWaitRes = 3'd3,
        StDone    = 3'd4
    } state_e;

    // K*K for the legal window sides; table lookup keeps multipliers out.
    function automatic logic [4:0] win_elems(input logic [2:0] k);
        case (k)
            3'd1:    win_elems = 5'd1;
            3'd2:    win_elems = 5'd4;
            3'd3:    win_elems = 5'd9;
            3'd4:    win_elems = 5'd16;
            default: win_elems = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/max_pool_window_feeder_pool_addr_gen.sv
// Window/element address walker: kx fastest, then ky; windows ox fastest, then oy.
module max_pool_window_feeder_pool_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DIM_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [DIM_WIDTH-1:0]  map_w_i,
    input  logic [DIM_WIDTH-1:0]  map_h_i,
    input  logic [2:0]            pool_k_i,
    input  logic [2:0]            stride_i,
    input  logic                  step_elem_i,
    input  logic                  step_window_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  first_elem_o,
    output logic                  last_elem_o,
    output logic                  last_window_o
);

    localparam int unsigned EW = DIM_WIDTH + 2;

    logic [2:0]            k_q, k_d, s_q, s_d, kx_q, kx_d, ky_q, ky_d;
    logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d, px_q, px_d, py_q, py_d;
    logic [ADDR_WIDTH-1:0] rs_q, rs_d, line_q, line_d, win_q, win_d, row_q, row_d;
    logic [ADDR_WIDTH-1:0] w_in, w_ext, s_ext, rs_load;
    logic                  last_x, last_y;

    assign w_in  = ADDR_WIDTH'(map_w_i);
    assign w_ext = ADDR_WIDTH'(w_q);
    assign s_ext = ADDR_WIDTH'(s_q);

    // Row stride S*map_w from shifts and one add.
    always_comb begin
        case (stride_i)
            3'd2:    rs_load = w_in << 1;
            3'd3:    rs_load = (w_in << 1) + w_in;
            3'd4:    rs_load = w_in << 2;
            default: rs_load = w_in;
        endcase
    end

    // A next window fits only if its right/bottom edge stays inside the map.
    assign last_x = (EW'(px_q) + EW'(s_q) + EW'(k_q)) > EW'(w_q);
    assign last_y = (EW'(py_q) + EW'(s_q) + EW'(k_q)) > EW'(h_q);

    assign addr_o        = row_q + ADDR_WIDTH'(kx_q);
    assign first_elem_o  = (kx_q == 3'd0) && (ky_q == 3'd0);
    assign last_elem_o   = (kx_q == k_q - 3'd1) && (ky_q == k_q - 3'd1);
    assign last_window_o = last_x && last_y;

    always_comb begin
        k_d = k_q; s_d = s_q; w_d = w_q; h_d = h_q; rs_d = rs_q;
        kx_d = kx_q; ky_d = ky_q; px_d = px_q; py_d = py_q;
        line_d = line_q; win_d = win_q; row_d = row_q;
        if (load_i) begin
            k_d = pool_k_i; s_d = stride_i; w_d = map_w_i; h_d = map_h_i; rs_d = rs_load;
            kx_d = '0; ky_d = '0; px_d = '0; py_d = '0;
            line_d = base_addr_i; win_d = base_addr_i; row_d = base_addr_i;
        end else if (step_window_i) begin
            kx_d = '0;
            ky_d = '0;
            if (last_x) begin
                px_d   = '0;
                py_d   = py_q + DIM_WIDTH'(s_q);
                line_d = line_q + rs_q;
                win_d  = line_q + rs_q;
                row_d  = line_q + rs_q;
            end else begin
                px_d  = px_q + DIM_WIDTH'(s_q);
                win_d = win_q + s_ext;
                row_d = win_q + s_ext;
            end
        end else if (step_elem_i) begin
            if (kx_q == k_q - 3'd1) begin
                kx_d = '0;
                if (ky_q == k_q - 3'd1) begin
                    ky_d  = '0;
                    row_d = win_q;
                end else begin
                    ky_d  = ky_q + 3'd1;
                    row_d = row_q + w_ext;
                end
            end else begin
                kx_d = kx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q <= '0; s_q <= '0; w_q <= '0; h_q <= '0; rs_q <= '0;
            kx_q <= '0; ky_q <= '0; px_q <= '0; py_q <= '0;
            line_q <= '0; win_q <= '0; row_q <= '0;
        end else begin
            k_q <= k_d; s_q <= s_d; w_q <= w_d; h_q <= h_d; rs_q <= rs_d;
            kx_q <= kx_d; ky_q <= ky_d; px_q <= px_d; py_q <= py_d;
            line_q <= line_d; win_q <= win_d; row_q <= row_d;
        end
    end

endmodule

// File: rtl/max_pool_window_feeder.sv
// Sequences feature-map reads window by window into the FP16 max-pool compare unit.
module max_pool_window_feeder
    import max_pool_window_feeder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DIM_WIDTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [DIM_WIDTH-1:0]     map_w_i,
    input  logic [DIM_WIDTH-1:0]     map_h_i,
    input  logic [2:0]               pool_k_i,
    input  logic [2:0]               stride_i,
    output logic                     fm_rd_en_o,
    output logic [ADDR_WIDTH-1:0]    fm_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]    fm_rd_data_i,
    output logic                     cmp_valid_o,
    output logic                     cmp_first_o,
    output logic [DATA_WIDTH-1:0]    cmp_data_o,
    output logic [CLK_NUM_WIDTH-1:0] data_num_o,
    input  logic                     result_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     cfg_err_o
);

    state_e                   state_q, state_d;
    logic                     flag_q, flag_d;
    logic                     cmp_valid_q, cmp_first_q;
    logic                     cfg_err_q, cfg_err_d;
    logic [CLK_NUM_WIDTH-1:0] data_num_q, data_num_d;
    logic                     cfg_ok, load, step_elem, step_window;
    logic                     first_elem, last_elem, last_window;
    logic [ADDR_WIDTH-1:0]    gen_addr;

    assign cfg_ok = (pool_k_i != 3'd0) && (pool_k_i <= 3'd4) &&
                    (stride_i != 3'd0) && (stride_i <= 3'd4) &&
                    (DIM_WIDTH'(pool_k_i) <= map_w_i) && (DIM_WIDTH'(pool_k_i) <= map_h_i);

    max_pool_window_feeder_pool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_pool_addr_gen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_i        (load),
        .base_addr_i   (base_addr_i),
        .map_w_i       (map_w_i),
        .map_h_i       (map_h_i),
        .pool_k_i      (pool_k_i),
        .stride_i      (stride_i),
        .step_elem_i   (step_elem),
        .step_window_i (step_window),
        .addr_o        (gen_addr),
        .first_elem_o  (first_elem),
        .last_elem_o   (last_elem),
        .last_window_o (last_window)
    );

    always_comb begin
        state_d     = state_q;
        flag_d      = flag_q;
        cfg_err_d   = 1'b0;
        data_num_d  = data_num_q;
        load        = 1'b0;
        step_elem   = 1'b0;
        step_window = 1'b0;
        if (result_ready_i && (state_q inside {StIssue, StDrain, StWaitRes})) begin
            flag_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        load       = 1'b1;
                        data_num_d = CLK_NUM_WIDTH'(win_elems(pool_k_i));
                        state_d    = StIssue;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                step_elem = 1'b1;
                if (last_elem) state_d = StDrain;
            end
            StDrain: state_d = StWaitRes;
            StWaitRes: begin
                // Consuming the flag wins over a pulse arriving in the same cycle.
                if (flag_q) begin
                    flag_d      = 1'b0;
                    step_window = 1'b1;
                    state_d     = last_window ? StDone : StIssue;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            flag_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_first_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            data_num_q  <= '0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            cmp_valid_q <= fm_rd_en_o;
            cmp_first_q <= fm_rd_en_o && first_elem;
            cfg_err_q   <= cfg_err_d;
            data_num_q  <= data_num_d;
        end
    end

    assign fm_rd_en_o   = (state_q == StIssue);
    assign fm_rd_addr_o = fm_rd_en_o ? gen_addr : '0;
    assign cmp_valid_o  = cmp_valid_q;
    assign cmp_first_o  = cmp_first_q;
    assign cmp_data_o   = cmp_valid_q ? fm_rd_data_i : '0;
    assign data_num_o   = data_num_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_max_pool_window_feeder.sv
// Self-checking bench: table-driven frames, random frames against a nested-loop model, reset cases.
module tb_max_pool_window_feeder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] base_addr_i = '0;
    logic [7:0]  map_w_i = '0, map_h_i = '0;
    logic [2:0]  pool_k_i = '0, stride_i = '0;
    logic        fm_rd_en_o;
    logic [15:0] fm_rd_addr_o;
    logic [15:0] fm_rd_data_i = '0;
    logic        cmp_valid_o, cmp_first_o;
    logic [15:0] cmp_data_o;
    logic [7:0]  data_num_o;
    logic        result_ready_i = 1'b0;
    logic        busy_o, done_o, cfg_err_o;
    logic [15:0] ram_key = '0;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int k; int s; int w; int h; int base; int delay; int dbl; int bs; int key;
        int rej; int exp_num; int exp_win;
    } vec_t;

    max_pool_window_feeder dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .map_w_i        (map_w_i),
        .map_h_i        (map_h_i),
        .pool_k_i       (pool_k_i),
        .stride_i       (stride_i),
        .fm_rd_en_o     (fm_rd_en_o),
        .fm_rd_addr_o   (fm_rd_addr_o),
        .fm_rd_data_i   (fm_rd_data_i),
        .cmp_valid_o    (cmp_valid_o),
        .cmp_first_o    (cmp_first_o),
        .cmp_data_o     (cmp_data_o),
        .data_num_o     (data_num_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Feature-map RAM: word content is address XOR key, one-cycle read latency.
    always @(posedge clk_i) begin
        if (fm_rd_en_o) fm_rd_data_i <= fm_rd_addr_o ^ ram_key;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, fm_rd_en_o, 0);
        check({tag, "_rd_addr"}, fm_rd_addr_o, 0);
        check({tag, "_cmp_valid"}, cmp_valid_o, 0);
        check({tag, "_cmp_first"}, cmp_first_o, 0);
        check({tag, "_cmp_data"}, cmp_data_o, 0);
        check({tag, "_data_num"}, data_num_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_cfg_err"}, cfg_err_o, 0);
    endtask

    task automatic run_and_check(input vec_t v, input bit lit);
        logic [15:0] addr_q[$];
        logic [15:0] dat_q[$];
        int          rdc_q[$];
        bit          fst_q[$];
        int elems = 0, cd = -1, extra = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
        int bad_idle = 0, num_bad = 0, busy_after = 1, limit, kk, ow, oh, nwin, idx;
        bit done_prev = 0, finished = 0;
        logic [15:0] ea;

        limit   = (v.rej != 0) ? 6 : 3000;
        ram_key = 16'(v.key);
        @(negedge clk_i);
        base_addr_i = 16'(v.base);
        map_w_i     = 8'(v.w);
        map_h_i     = 8'(v.h);
        pool_k_i    = 3'(v.k);
        stride_i    = 3'(v.s);
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= limit && !finished; cyc++) begin
            if (done_prev) begin
                busy_after = int'(busy_o);
                finished   = 1'b1;
            end
            if (fm_rd_en_o) begin
                addr_q.push_back(fm_rd_addr_o);
                rdc_q.push_back(cyc);
            end
            if (cmp_valid_o) begin
                dat_q.push_back(cmp_data_o);
                fst_q.push_back(cmp_first_o);
                elems++;
            end else if (cmp_data_o != 16'd0 || cmp_first_o) begin
                bad_idle++;
            end
            if (cfg_err_o) err_cnt++;
            if (busy_o && !done_prev) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_prev = 1'b1;
            end
            if (v.rej == 0 && data_num_o != 8'(v.exp_num)) num_bad++;
            // Compare-unit stand-in: result pulse `delay` cycles after a window's last element.
            result_ready_i = 1'b0;
            if (v.rej == 0 && elems == v.k * v.k) begin
                elems = 0;
                cd    = v.delay;
            end
            if (cd == 0) begin
                result_ready_i = 1'b1;
                extra = v.dbl;
                cd    = -1;
            end else if (cd > 0) begin
                cd--;
            end else if (extra != 0) begin
                result_ready_i = 1'b1;
                extra = 0;
            end
            start_i = (cyc == v.bs);
            if (cyc == v.bs) begin
                base_addr_i = base_addr_i ^ 16'h0040;
                pool_k_i    = 3'd0;
            end
            @(negedge clk_i);
        end
        result_ready_i = 1'b0;
        start_i        = 1'b0;

        if (v.rej != 0) begin
            check("rej_cfg_err_cycles", err_cnt, 1);
            check("rej_busy_cycles", busy_cnt, 0);
            check("rej_reads", addr_q.size(), 0);
            check("rej_done", done_cnt, 0);
        end else begin
            kk   = v.k * v.k;
            ow   = (v.w - v.k) / v.s + 1;
            oh   = (v.h - v.k) / v.s + 1;
            nwin = ow * oh;
            check("frame_finished", finished, 1);
            check("window_count", dat_q.size() / kk, v.exp_win);
            check("model_window_count", nwin, v.exp_win);
            check("read_count", addr_q.size(), nwin * kk);
            check("data_num_stable", num_bad, 0);
            check("first_read_cycle", (rdc_q.size() > 0) ? rdc_q[0] : -1, 1);
            check("done_pulses", done_cnt, 1);
            check("busy_after_done", busy_after, 0);
            check("no_cfg_err", err_cnt, 0);
            check("idle_cmp_zero", bad_idle, 0);
            idx = 0;
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    for (int ky = 0; ky < v.k; ky++)
                        for (int kx = 0; kx < v.k; kx++) begin
                            ea = 16'(v.base + (oy * v.s + ky) * v.w + ox * v.s + kx);
                            if (idx < addr_q.size()) check("rd_addr", addr_q[idx], ea);
                            if (idx < dat_q.size()) begin
                                check("cmp_data", dat_q[idx], ea ^ 16'(v.key));
                                check("cmp_first", fst_q[idx], (kx == 0 && ky == 0));
                            end
                            idx++;
                        end
            if (v.delay == 0 && nwin > 1 && rdc_q.size() > kk)
                check("window_gap", rdc_q[kk] - rdc_q[kk-1], 3);
            if (lit && addr_q.size() >= 16) begin
                check("win0_addr0", addr_q[0], 16'h100);
                check("win0_addr1", addr_q[1], 16'h101);
                check("win0_addr2", addr_q[2], 16'h104);
                check("win0_addr3", addr_q[3], 16'h105);
                check("win3_addr0", addr_q[12], 16'h10A);
                check("win3_addr1", addr_q[13], 16'h10B);
                check("win3_addr2", addr_q[14], 16'h10E);
                check("win3_addr3", addr_q[15], 16'h10F);
            end
        end
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   dn;

        //          k  s  w  h  base     dly dbl bs key      rej num win
        tbl[0] = '{2, 2, 4, 4, 'h100,   3,  0,  0, 'h5A5A,  0,  4,  4};
        tbl[1] = '{3, 1, 3, 3, 'h200,   2,  0,  0, 'h1234,  0,  9,  1};
        tbl[2] = '{3, 1, 5, 5, 'h0,     0,  0,  0, 'h0,     0,  9,  9};
        tbl[3] = '{3, 1, 2, 4, 'h300,   1,  0,  0, 'h0,     1,  0,  0};
        tbl[4] = '{2, 0, 4, 4, 'h300,   1,  0,  0, 'h0,     1,  0,  0};
        tbl[5] = '{2, 1, 5, 4, 'h40,    3,  1,  4, 'hA5A5,  0,  4, 12};
        tbl[6] = '{1, 3, 7, 4, 'h800,   1,  0,  2, 'h0F0F,  0,  1,  6};
        tbl[7] = '{4, 4, 8, 9, 'hFFF0,  2,  0,  0, 'hFFFF,  0, 16,  4};

        #1 rst_i = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_outputs_zero("post_reset");

        for (int i = 0; i < 8; i++) run_and_check(tbl[i], (i == 0));

        // Reset while window 0 is being read, then replay the same frame.
        @(negedge clk_i);
        base_addr_i = 16'h100; map_w_i = 8'd4; map_h_i = 8'd4;
        pool_k_i = 3'd2; stride_i = 3'd2; ram_key = 16'h5A5A;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check("pre_reset_busy", busy_o, 1);
        check("pre_reset_cmp_valid", cmp_valid_o, 1);
        rst_i = 1'b1;
        #1 check_outputs_zero("mid_reset");
        dn = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) dn++;
        end
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) dn++;
        end
        check("no_done_after_abort", dn, 0);
        check("idle_after_abort", busy_o, 0);
        run_and_check(tbl[0], 1'b1);

        for (int r = 0; r < 12; r++) begin
            v.k     = int'($urandom_range(1, 4));
            v.s     = int'($urandom_range(1, 4));
            v.w     = int'($urandom_range(v.k, 9));
            v.h     = int'($urandom_range(v.k, 9));
            v.base  = int'($urandom_range(0, 65535));
            v.delay = int'($urandom_range(0, 4));
            v.dbl   = int'($urandom_range(0, 1));
            v.bs    = int'($urandom_range(0, 3));
            v.key   = int'($urandom_range(0, 65535));
            v.rej   = 0;
            v.exp_num = v.k * v.k;
            v.exp_win = ((v.w - v.k) / v.s + 1) * ((v.h - v.k) / v.s + 1);
            run_and_check(v, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/max_pool_window_feeder.md
# max_pool_window_feeder

Address generator and sequencer directly upstream of the FP16 max-pool compare unit. On a start pulse it walks a feature map stored in the feature-map RAM in pooling-window order. For each K×K window it streams the K² FP16 elements to the compare unit, presents the element count on `data_num`, and waits for the unit's `result_ready` before issuing the next window. It pulses `done` after the last window's result is returned.

## Interface
Parameters:
- `DATA_WIDTH`, 16: FP16 element width, from the shared header.
- `CLK_NUM_WIDTH`, 8: width of `data_num`, from the shared header.
- `ADDR_WIDTH`, 16: feature-map RAM word address width.
- `DIM_WIDTH`, 8: width of map-dimension fields.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches the configuration. Honoured only in IDLE.
- `base_addr`  in  ADDR_WIDTH  RAM address of map element (0,0); row-major layout.
- `map_w`, `map_h`  in  DIM_WIDTH  map width and height in elements.
- `pool_k`  in  3  window side K; legal range 1..4.
- `stride`  in  3  window step S; legal range 1..4.
- `fm_rd_en`  out  1  RAM read strobe.
- `fm_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `fm_rd_data`  in  DATA_WIDTH  RAM data; valid exactly 1 cycle after `fm_rd_en`.
- `cmp_valid`  out  1  `cmp_data` holds a window element this cycle.
- `cmp_first`  out  1  high with the first element of each window.
- `cmp_data`  out  DATA_WIDTH  element to the compare unit; 0 when `cmp_valid` is low.
- `data_num`  out  CLK_NUM_WIDTH  K², stable from `start` acceptance until `done`.
- `result_ready`  in  1  one-cycle pulse from the compare unit marking the window result.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse after the last result.
- `cfg_err`  out  1  one-cycle pulse when a start is rejected.

## Operation
- Reset: all outputs are 0, state is IDLE, and counters and the sticky flag are cleared. Reset asserted mid-frame aborts the frame immediately with no `done`; pending RAM data is discarded.
- Derived values on accept: `out_w = (map_w-K)/S + 1`, `out_h = (map_h-K)/S + 1`, `data_num = K*K` (zero-extended).
- A start is rejected, producing a `cfg_err` pulse and remaining in IDLE, when any of these holds: K=0, K>4, S=0, S>4, K>map_w, K>map_h.
- Element address is `base + (oy*S + ky)*map_w + ox*S + kx`. It is computed incrementally with adders only; no multipliers.
- Element order inside a window: kx fastest, then ky.
- Window order: ox fastest, then oy.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not flagged.
- FSM states:
  - IDLE: a legal `start` goes to ISSUE.
  - ISSUE: asserts `fm_rd_en` for K² consecutive cycles, then goes to DRAIN.
  - DRAIN: one cycle while the last data returns, then goes to WAIT_RES.
  - WAIT_RES: on the sticky result flag, clears it and advances the window. If that was the last window it goes to DONE; otherwise it goes to ISSUE.
  - DONE: pulses `done` for one cycle, then goes to IDLE.
- Sticky result flag: set by a `result_ready` pulse in ISSUE, DRAIN or WAIT_RES. A pulse in IDLE or DONE is ignored. A second pulse before the flag is consumed is absorbed without error.
- `start` while `busy` is ignored; it does not raise `cfg_err`.

## Timing
- A start accepted at edge N puts the first `fm_rd_en` at cycle N+1.
- `fm_rd_en` stays high for cycles N+1..N+K².
- `cmp_valid` = `fm_rd_en` delayed one cycle; `cmp_first` is high at N+2.
- The last element appears at N+K²+1, which is the DRAIN cycle.
- The next window's first read comes 1 cycle after the flag is seen in WAIT_RES. Minimum gap between windows: last read → DRAIN → WAIT_RES → ISSUE, i.e. 2 idle cycles.
- `busy` rises the cycle after accept and falls the cycle after the `done` pulse.
- K=1 case: one read per window, so `cmp_first` and `cmp_valid` are high on the same single cycle.

## Structure
- The shared CNN parameter header owns `DATA_WIDTH`, `CLK_NUM_WIDTH` and the state encodings (IDLE=0, ISSUE=1, DRAIN=2, WAIT_RES=3, DONE=4).
- One natural sub-module is `pool_addr_gen`. It holds the kx/ky/ox/oy counters and the row/window base registers, and exposes `step_elem`, `step_window`, `last_elem` and `last_window`.
- The FSM, data delay and sticky flag live in the top level.

## Test plan
- 4×4 map, K=2, S=2, base 0x100, `result_ready` 3 cycles after each last element:
  - `data_num`=4 and 4 windows.
  - Window 0 addresses 0x100,0x101,0x104,0x105.
  - Window 3 addresses 0x10A,0x10B,0x10E,0x10F.
  - One `done` pulse.
- 3×3 map, K=3, S=1: a single window of 9 consecutive addresses; `data_num`=9; `cmp_first` only on the first element; `done` follows the result.
- 5×5 map, K=3, S=1, with RAM data equal to the address: 9 windows with `cmp_data` matching the addresses. A `result_ready` in the DRAIN cycle is honoured and the next ISSUE starts 2 cycles later.
- Rejected starts: K=3 on a 2×4 map gives `cfg_err` for 1 cycle, `busy` stays 0 and there is no `fm_rd_en`. S=0 gives the same response.
- Reset mid-window: all outputs are 0 within the reset cycle, with no `done`. A fresh start afterwards replays window 0 correctly.
- `start` pulsed while busy is ignored and the frame completes unchanged. A double `result_ready` in WAIT_RES advances by exactly one window.
